// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared encodings for the memory-port arbiter: FSM state codes, owner
//   codes and the round-robin winner selection used at grant time.
//   No ports (package).
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // FSM state encoding. Plain 2-bit constants so the state register can be
  // probed or forced by legacy tools that do not understand enums.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Owner of the transaction currently in flight.
  typedef logic owner_t;
  localparam owner_t OWN_CORE   = 1'b0;
  localparam owner_t OWN_LOADER = 1'b1;

  // Round-robin pick between the two requesters. A lone requester always
  // wins; on a tie the side that was not granted last time wins, which
  // gives strict alternation when both keep requesting.
  function automatic owner_t pick_winner(input logic   c_req,
                                         input logic   l_req,
                                         input owner_t last_gnt);
    owner_t win;
    if (c_req && l_req) begin
      win = (last_gnt == OWN_CORE) ? OWN_LOADER : OWN_CORE;
    end else if (c_req) begin
      win = OWN_CORE;
    end else begin
      win = OWN_LOADER;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three sides of the arbiter: core requester (c_*), loader
//   requester (l_*) and the memory macro (m_*), plus the busy flag.
//   Modports:
//     slave  - the arbiter's view (requests and m_rdata in; acks, read data,
//              busy and the memory command out)
//     master - the environment's view (requesters plus memory macro)
//   Parameters: AW address width, DW data width.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // core requester
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic [DW-1:0] c_rdata;

  // loader requester
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_ack;
  logic [DW-1:0] l_rdata;

  // status
  logic          busy;

  // memory macro
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_ack, c_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_ack, l_rdata,
    output busy,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_ack, c_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_ack, l_rdata,
    input  busy,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single memory port between the core (fetch, LW/SW) and the
//   program loader / debug DMA. One transaction at a time: the winning
//   request is latched, strobed to memory for one cycle, the fixed read
//   latency is counted out, then the owner gets a one-cycle ack together
//   with its read data.
//
//   Ports:
//     clk  - clock, all state on the rising edge
//     rst  - asynchronous active-low reset
//     bus  - mem_port_arbiter_if.slave (c_*, l_*, busy, m_*)
//
//   Parameters:
//     AW, DW   address / data width (must match the interface instance)
//     MEM_LAT  cycles from m_en to valid m_rdata, >= 1
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no transaction; sample requests, latch the winner's fields
//   ISSUE | m_en high for this single cycle; load the latency counter
//   WAIT  | count down the remaining read latency
//   DONE  | ack the owner; capture m_rdata for reads
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  // Counter is sized to hold MEM_LAT-1 and only counts down to 1, so it
  // can never wrap.
  localparam int              CW        = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  // With a single-cycle memory there is nothing to wait for.
  localparam logic [1:0]      ST_AFTER_ISSUE = (MEM_LAT > 1) ? ST_WAIT : ST_DONE;

  logic [1:0]    state_q,    state_d;
  owner_t        owner_q,    owner_d;
  owner_t        last_gnt_q, last_gnt_d;
  logic          we_q,       we_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [DW-1:0] wdata_q,    wdata_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [DW-1:0] c_rdata_q,  c_rdata_d;
  logic [DW-1:0] l_rdata_q,  l_rdata_d;

  owner_t        winner;
  logic          any_req;
  logic          in_done;
  logic          c_done;
  logic          l_done;

  // -------------------------------------------------------------------------
  // Arbitration decision
  // -------------------------------------------------------------------------
  assign any_req = bus.c_req | bus.l_req;
  assign winner  = pick_winner(bus.c_req, bus.l_req, last_gnt_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    c_rdata_d  = c_rdata_q;
    l_rdata_d  = l_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // All request fields are frozen here; anything the requester
          // does afterwards has no effect on this transaction.
          owner_d    = winner;
          last_gnt_d = winner;
          if (winner == OWN_LOADER) begin
            we_d    = bus.l_we;
            addr_d  = bus.l_addr;
            wdata_d = bus.l_wdata;
          end else begin
            we_d    = bus.c_we;
            addr_d  = bus.c_addr;
            wdata_d = bus.c_wdata;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_AFTER_ISSUE;
      end

      ST_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        // Writes leave the owner's read-data register untouched.
        if (!we_q) begin
          if (owner_q == OWN_LOADER) begin
            l_rdata_d = bus.m_rdata;
          end else begin
            c_rdata_d = bus.m_rdata;
          end
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_CORE;
      // Loader counts as last granted so the core wins the first tie.
      last_gnt_q <= OWN_LOADER;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Strobes decode straight from the state register, so a reset drops them
  // in the same instant the state returns to IDLE.
  assign in_done = (state_q == ST_DONE);
  assign c_done  = in_done & (owner_q == OWN_CORE);
  assign l_done  = in_done & (owner_q == OWN_LOADER);

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.m_en    = (state_q == ST_ISSUE);
  assign bus.m_we    = (state_q == ST_ISSUE) & we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  assign bus.c_ack   = c_done;
  assign bus.l_ack   = l_done;

  // m_rdata is only valid during the DONE cycle, so the ack cycle forwards
  // it directly; the register then holds it until the owner's next read.
  assign bus.c_rdata = (c_done & ~we_q) ? bus.m_rdata : c_rdata_q;
  assign bus.l_rdata = (l_done & ~we_q) ? bus.m_rdata : l_rdata_q;

endmodule
